alu_muldiv_sequencer: RTL and testbench

//   Iterative multiply/divide controller beside the ALU in the execute stage.

---
 rtl/alu_muldiv_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: ops with src2==0 skip the iteration phase.
module alu_muldiv_sequencer #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned AW = 2 * XLEN;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t            state, state_n;
   logic              accept_c;
   logic              early_c;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_q;
   logic              neg1, neg2, early_q;
   logic [XLEN-1:0]   opnd, src1_q;
   logic [AW-1:0]     acc, acc_step, prod_s;
   logic              s1_signed, s2_signed, neg1_c, neg2_c;
   logic [XLEN-1:0]   mag1, mag2, quo_s, rem_s, res_c;
   logic [XLEN:0]     sum, rem_sh, diff;

`ifdef MULDIV_EARLY_OUT_EN
   assign early_c = (src2 == '0);
`else
   assign early_c = 1'b0;
`endif

   // Operand sign handling at accept: signed operands are stored as magnitudes.
   always_comb begin
      s1_signed = op[2] ? !op[0] : (op != 3'd3);
      s2_signed = op[2] ? !op[0] : !op[1];
      neg1_c    = s1_signed & src1[XLEN-1];
      neg2_c    = s2_signed & src2[XLEN-1];
      mag1      = neg1_c ? -src1 : src1;
      mag2      = neg2_c ? -src2 : src2;
   end

   // One multiply or divide step on the {hi, lo} accumulator.
   always_comb begin
      sum    = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      rem_sh = acc[AW-1:XLEN-1];
      diff   = rem_sh - {1'b0, opnd};
      if (op_q[2]) begin
         acc_step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
         acc_step = {sum, acc[XLEN-1:1]};
      end
   end

   // Sign correction and result selection.
   always_comb begin
      prod_s = (neg1 ^ neg2) ? -acc : acc;
      quo_s  = (neg1 ^ neg2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_s  = neg1 ? -acc[AW-1:XLEN] : acc[AW-1:XLEN];
      case (op_q)
         3'd0:         res_c = prod_s[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:         res_c = prod_s[AW-1:XLEN];
         3'd4, 3'd5:   res_c = (opnd == '0) ? '1 : quo_s;
         default:      res_c = (opnd == '0) ? src1_q : rem_s;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      accept_c = 1'b0;
      case (state)
         IDLE: begin
            if (start && !flush) begin
               accept_c = 1'b1;
               state_n  = early_c ? FIX : RUN;
            end
         end
         RUN: begin
            if (flush)                              state_n = IDLE;
            else if (cnt == CNT_W'(XLEN - 1))       state_n = FIX;
         end
         FIX:     state_n = flush ? IDLE : DONE;
         DONE: begin
            state_n = IDLE;
            if (start && !flush) begin
               accept_c = 1'b1;
               state_n  = early_c ? FIX : RUN;
            end
         end
         default: state_n = IDLE;
      endcase
      stall = (state == IDLE && start) || (state == RUN) || (state == FIX && !early_q);
   end

   // Status, result and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         cnt     <= '0;
         op_q    <= '0;
         neg1    <= 1'b0;
         neg2    <= 1'b0;
         early_q <= 1'b0;
         opnd    <= '0;
         src1_q  <= '0;
         acc     <= '0;
      end else begin
         busy <= (state_n != IDLE);
         done <= (state_n == DONE);
         if (state == FIX && !flush) result <= res_c;
         if (accept_c) begin
            op_q    <= op;
            neg1    <= neg1_c;
            neg2    <= neg2_c;
            early_q <= early_c;
            src1_q  <= src1;
            cnt     <= '0;
            opnd    <= op[2] ? mag2 : mag1;
            acc     <= {XLEN'(0), (op[2] ? mag1 : mag2)};
         end else if (state == RUN) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench for alu_muldiv_sequencer: directed corner cases plus random ops
// against an arithmetic reference model. Honours MULDIV_EARLY_OUT_EN for latency.
module tb_alu_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] src1 = 32'd0;
   logic [31:0] src2 = 32'd0;
   logic        busy, stall, done;
   logic [31:0] result;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] last_res = 32'd0;

   alu_muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
      .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      p;
      logic [63:0] pv;
      int          sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      case (o)
         3'd0, 3'd1: begin p = longint'(sa) * longint'(sb); pv = p; end
         3'd2:       begin p = longint'(sa) * longint'({32'd0, b}); pv = p; end
         default:    pv = {32'd0, a} * {32'd0, b};
      endcase
      case (o)
         3'd0:       return pv[31:0];
         3'd1, 3'd2,
         3'd3:       return pv[63:32];
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'd5:       return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default:    return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      return (b == 32'd0) ? 2 : 34;
`else
      return 34;
`endif
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   // Present an op for one cycle from IDLE; returns at cycle 1 (#1 after the following negedge).
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; src1 = a; src2 = b; start = 1'b1;
      #1 check("stall_accept", 32'(stall), 32'd1);
      @(negedge clk);
      start = 1'b0;
      #1;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int          cyc;
      logic [31:0] exp;
      exp = model(o, a, b);
      issue(o, a, b);
      check({tag, "_stall_run"}, 32'(stall), (exp_lat(b) == 2) ? 32'd0 : 32'd1);
      wait_done(cyc);
      check({tag, "_latency"}, 32'(cyc), 32'(exp_lat(b)));
      check({tag, "_result"}, result, exp);
      check({tag, "_stall_done"}, 32'(stall), 32'd0);
      last_res = exp;
      @(negedge clk);
      #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int   cyc;
      logic saw_done;

      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      rst = 1'b0;

      run_check("mul_7_m3",    3'd0, 32'd7, 32'hFFFF_FFFD);
      run_check("mulhu_ones",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_check("mulh_ones",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_check("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2);
      run_check("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2);
      run_check("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_check("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      run_check("divu_5_0",    3'd5, 32'd5, 32'd0);
      run_check("remu_5_0",    3'd7, 32'd5, 32'd0);
      run_check("div_m5_0",    3'd4, 32'hFFFF_FFFB, 32'd0);
      run_check("rem_m5_0",    3'd6, 32'hFFFF_FFFB, 32'd0);
      run_check("mul_x_0",     3'd0, 32'h1234_5678, 32'd0);

      // Flush at cycle 10 of a DIV: no done, result unchanged.
      saw_done = 1'b0;
      issue(3'd4, 32'd100, 32'd7);
      repeat (9) begin
         @(negedge clk);
         #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("flush_busy_before", 32'(busy), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_busy_after", 32'(busy), 32'd0);
      repeat (40) begin
         @(negedge clk);
         #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("flush_no_done", 32'(saw_done), 32'd0);
      check("flush_result_kept", result, last_res);

      // Start together with flush in IDLE is ignored.
      @(negedge clk);
      op = 3'd0; src1 = 32'd2; src2 = 32'd2; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check("flush_start_ignored", 32'(busy), 32'd0);

      // Reset pulse in the middle of a multiply.
      issue(3'd0, 32'd9, 32'd11);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_stall", 32'(stall), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_res = 32'd0;

      // MUL 3*4, then a back-to-back MUL 5*6 issued in the done cycle.
      issue(3'd0, 32'd3, 32'd4);
      wait_done(cyc);
      check("b2b_first_latency", 32'(cyc), 32'd34);
      check("b2b_first_result", result, 32'd12);
      check("b2b_stall_done", 32'(stall), 32'd0);
      op = 3'd0; src1 = 32'd5; src2 = 32'd6; start = 1'b1;
      #1 check("b2b_stall_done_start", 32'(stall), 32'd0);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_done_low", 32'(done), 32'd0);
      check("b2b_stall_run", 32'(stall), 32'd1);
      wait_done(cyc);
      check("b2b_second_latency", 32'(cyc), 32'd34);
      check("b2b_second_result", result, 32'd30);
      @(negedge clk);
      #1;
      check("b2b_done_pulse", 32'(done), 32'd0);

      for (int i = 0; i < 30; i++) begin
         logic [2:0]  ro;
         logic [31:0] ra, rb;
         ro = 3'($urandom_range(0, 7));
         ra = pick();
         rb = pick();
         run_check("rand", ro, ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
